// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states,
// the SYSTEM opcode and the PC / write-back source selects.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expire flags the cycle that would
// be the LIMIT-th consecutive wait.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = count && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, with a wait timeout and perf counters.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction read on the shared port, IR loads on mem_ready
// DECODE | decoder settles; SYSTEM opcode halts
// EXEC   | ALU cycle; branches retire here
// MEM    | load/store data access; stores retire here
// WB     | register write-back and PC update
// HALT   | ECALL/EBREAK seen, sticky until reset
// ERROR  | memory wait timeout, sticky until reset
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      inst,
  input  logic             EscReg,
  input  logic             EscMem,
  input  logic             lw,
  input  logic             jump,
  input  logic             jalr,
  input  logic             Branch,
  input  logic             lui,
  input  logic             auiPc,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  state_t state_q, state_d;
  logic   is_mem;
  logic   retire;
  logic   tmr_clear;
  logic   tmr_expire;
  logic   unused_inputs;

  // AUIPC needs no special write-back source; the ALU already forms PC+imm.
  assign unused_inputs = ^{inst[31:7], auiPc};

  assign is_mem = lw | EscMem;

  // Any cycle without an outstanding wait restarts the consecutive count.
  assign tmr_clear = ~mem_req | mem_ready;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .count (mem_req & ~mem_ready),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)       state_d = ST_DECODE;
        else if (tmr_expire) state_d = ST_ERROR;
      end
      ST_DECODE: state_d = (inst[6:0] == OPC_SYSTEM) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (is_mem)      state_d = ST_MEM;
        else if (Branch) state_d = ST_FETCH;
        else             state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)       state_d = EscMem ? ST_FETCH : ST_WB;
        else if (tmr_expire) state_d = ST_ERROR;
      end
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_SEL_PC4;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      ST_EXEC: begin
        if (!is_mem && Branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
          retire   = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = EscMem;
        if (mem_ready && EscMem) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        rf_we    = ~EscReg;
        pc_write = 1'b1;
        retire   = 1'b1;
        if (lw)               wb_sel = WB_SEL_MEM;
        else if (jump | jalr) wb_sel = WB_SEL_PC4;
        else if (lui)         wb_sel = WB_SEL_IMM;
        if (jump)             pc_sel = PC_SEL_IMM;
        else if (jalr)        pc_sel = PC_SEL_ALU;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
  assign halted = (state_q == ST_HALT);
  assign error  = (state_q == ST_ERROR);
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, busy};
      instret     <= instret + {{(CNT_W-1){1'b0}}, retire};
    end
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the RV32 core; sequences fetch/decode/execute/memory/writeback around the combinational instruction decoder.
- Consumes decoder flags plus the ALU branch-compare result.
- Drives PC, IR, register-file and memory-port enables.
- Owns the single shared instruction/data memory port (req/ready handshake), a wait timeout, and cycle/retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_count and instret.
- MEM_TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before entering ERROR (>=2).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE.
- inst  in  32  current IR contents.
- EscReg  in  1  decoder flag; 1 = instruction does NOT write the register file.
- EscMem  in  1  decoder flag; store.
- lw  in  1  decoder flag; load.
- jump  in  1  decoder flag; JAL.
- jalr  in  1  decoder flag; JALR.
- Branch  in  1  decoder flag; conditional branch.
- lui  in  1  decoder flag; LUI.
- auiPc  in  1  decoder flag; AUIPC.
- branch_taken  in  1  ALU compare result, valid in EXEC.
- mem_ready  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_load  out  1  capture memory read data into IR.
- pc_write  out  1  update PC.
- pc_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result & ~1.
- rf_we  out  1  register-file write enable.
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate.
- busy  out  1  state is not IDLE, HALT or ERROR.
- halted  out  1  state is HALT.
- error  out  1  state is ERROR.
- state  out  3  current state, for debug.
- cycle_count  out  CNT_W  cycles spent busy.
- instret  out  CNT_W  retired instructions.

Behaviour:
- Clocking and reset:
  - The block has one clock, clk.
  - reset is synchronous and active-high.
  - On reset: state=IDLE, both counters 0, timeout counter 0, all outputs 0.
  - Reset mid-transaction drops mem_req on the next edge; no write is issued.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Output rule: all outputs are Moore except ir_load and MEM/WB completion strobes, which are qualified by mem_ready in the same cycle. Unlisted outputs are 0.
- IDLE: start=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0, held until mem_ready.
  - On mem_ready: ir_load=1 -> DECODE.
- DECODE:
  - inst[6:0]==7'b1110011 (ECALL/EBREAK) -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - lw|EscMem -> MEM.
  - Else if Branch: pc_write=1, pc_sel = branch_taken ? 01 : 00, instret++ -> FETCH.
  - Else -> WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=EscMem.
  - On mem_ready with store: pc_write=1, pc_sel=00, instret++ -> FETCH.
  - On mem_ready with load -> WB.
- WB:
  - rf_we = ~EscReg.
  - wb_sel: 01 if lw; 10 if jump|jalr; 11 if lui; else 00. AUIPC uses 00 (ALU computes PC+imm).
  - pc_write=1; pc_sel: 01 if jump, 10 if jalr, else 00.
  - instret++ -> FETCH.
- Zero-wait latency: ALU/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch 3. Each mem wait cycle adds 1.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - At MEM_TIMEOUT consecutive waiting cycles -> ERROR. mem_ready arriving in that same cycle wins.
- HALT and ERROR are sticky until reset; start is ignored there.
- start while busy is ignored. mem_ready while mem_req=0 is ignored.
- cycle_count increments every cycle busy=1.
- Both counters wrap modulo 2^CNT_W.

Decomposition:
- Package riscv_ctrl_pkg holds: state encoding, OPC_SYSTEM=7'b1110011, and the PC_SEL_* and WB_SEL_* encodings.
- One sub-module, mem_wait_timer: clear/count/expire, width $clog2(MEM_TIMEOUT+1).

Test Plan:
- Reset, start, ADDI 0x00500093, mem_ready tied 1 -> states 1,2,3,5; in WB rf_we=1, wb_sel=00, pc_write=1, pc_sel=00; instret=1, cycle_count=4.
- LW 0x0000A103, mem_ready delayed 3 cycles in MEM -> mem_req/mem_addr_sel=1 held 4 cycles, mem_we=0; WB wb_sel=01, rf_we=1; total 8 cycles.
- SW 0x0020A023 -> MEM mem_we=1; next state FETCH; rf_we never asserted; pc_sel=00.
- BLT 0x0020C463 with branch_taken=1 then 0 -> EXEC pc_sel=01 then 00, rf_we=0.
- JAL 0x008000EF -> WB wb_sel=10, pc_sel=01.
- ECALL 0x00000073 -> HALT, halted=1; start pulse ignored; cycle_count frozen.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> error=1 after 4 request cycles.
- Reset asserted mid-MEM -> IDLE and mem_req=0 next edge.
